// File: rtl/mac_layer_sequencer.sv
// Drives one MAC through a dense layer: bias load, N_IN weight/activation
// pairs per neuron, ReLU/requantise/saturate, then one output byte per neuron.
module mac_layer_sequencer #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int WA_W  = 8,
  parameter int AA_W  = 4,
  parameter int OA_W  = 3,
  parameter int RELU  = 1
) (
  input  logic            CLKEXT,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [WA_W-1:0] w_addr,
  output logic [AA_W-1:0] a_addr,
  output logic [OA_W-1:0] b_addr,
  input  logic [7:0]      b_data,
  output logic            EN_MAC,
  output logic            RST_MAC,
  output logic [7:0]      BIAS_OUT,
  input  logic [15:0]     MAC_result,
  output logic            o_wr,
  output logic [OA_W-1:0] o_addr,
  output logic [7:0]      o_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_ACC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AA_W-1:0] K_LAST = AA_W'(N_IN - 1);
  localparam logic [OA_W-1:0] J_LAST = OA_W'(N_OUT - 1);

  state_t          state_q, state_d;
  logic [OA_W-1:0] j_q, j_d;
  logic [AA_W-1:0] k_q, k_d;
  logic [WA_W-1:0] w_q, w_d;

  logic signed [15:0] shifted;
  logic        [7:0]  quant;

  always_ff @(posedge CLKEXT) begin
    if (reset) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      w_q     <= w_d;
    end
  end

  // w_q runs on through the whole layer: after a neuron's last ACC cycle it
  // already holds the next neuron's base address, so no multiply is needed.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BIAS;
          j_d     = '0;
          k_d     = '0;
          w_d     = '0;
        end
      end
      S_BIAS: begin
        state_d = S_ACC;
        k_d     = '0;
      end
      S_ACC: begin
        w_d = w_q + WA_W'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + AA_W'(1);
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (j_q == J_LAST) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + OA_W'(1);
          state_d = S_BIAS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        j_d     = '0;
        w_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requantise Q.4 accumulator to int8 with optional ReLU.
  always_comb begin
    shifted = $signed(MAC_result) >>> 4;
    if ((RELU != 0) && shifted[15]) shifted = '0;
    if (shifted > 16'sd127)       quant = 8'h7F;
    else if (shifted < -16'sd128) quant = 8'h80;
    else                          quant = shifted[7:0];
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    EN_MAC   = (state_q == S_ACC) || (state_q == S_DRAIN);
    RST_MAC  = (state_q == S_ACC) && (k_q == '0);
    o_wr     = (state_q == S_WRITE);
    w_addr   = w_q;
    a_addr   = k_q;
    b_addr   = j_q;
    o_addr   = j_q;
    BIAS_OUT = b_data;
    o_data   = (state_q == S_WRITE) ? quant : '0;
  end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for mac_layer_sequencer: two instances (ReLU on/off) with memory and
// saturating-MAC models; expectations come from a per-neuron dot-product model.
module tb_mac_layer_sequencer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int WA_W  = 3;
  localparam int AA_W  = 2;
  localparam int OA_W  = 1;
  localparam int PER   = N_IN + 3;
  localparam int TOTAL = N_OUT * PER;

  logic            CLKEXT;
  logic            reset;
  logic            start;
  logic            busy       [2];
  logic            done       [2];
  logic [WA_W-1:0] w_addr     [2];
  logic [AA_W-1:0] a_addr     [2];
  logic [OA_W-1:0] b_addr     [2];
  logic [7:0]      b_data     [2];
  logic            EN_MAC     [2];
  logic            RST_MAC    [2];
  logic [7:0]      BIAS_OUT   [2];
  logic [15:0]     MAC_result [2];
  logic            o_wr       [2];
  logic [OA_W-1:0] o_addr     [2];
  logic [7:0]      o_data     [2];

  logic [7:0] wmem [N_IN*N_OUT];
  logic [7:0] amem [N_IN];
  logic [7:0] bmem [N_OUT];

  logic [7:0]         w_rd [2];
  logic [7:0]         a_rd [2];
  logic signed [15:0] acc  [2];

  int vecs = 0;
  int errs = 0;

  mac_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WA_W(WA_W), .AA_W(AA_W), .OA_W(OA_W), .RELU(1)
  ) dut_relu (
    .CLKEXT(CLKEXT), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .w_addr(w_addr[0]), .a_addr(a_addr[0]), .b_addr(b_addr[0]), .b_data(b_data[0]),
    .EN_MAC(EN_MAC[0]), .RST_MAC(RST_MAC[0]), .BIAS_OUT(BIAS_OUT[0]),
    .MAC_result(MAC_result[0]), .o_wr(o_wr[0]), .o_addr(o_addr[0]), .o_data(o_data[0])
  );

  mac_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WA_W(WA_W), .AA_W(AA_W), .OA_W(OA_W), .RELU(0)
  ) dut_lin (
    .CLKEXT(CLKEXT), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .w_addr(w_addr[1]), .a_addr(a_addr[1]), .b_addr(b_addr[1]), .b_data(b_data[1]),
    .EN_MAC(EN_MAC[1]), .RST_MAC(RST_MAC[1]), .BIAS_OUT(BIAS_OUT[1]),
    .MAC_result(MAC_result[1]), .o_wr(o_wr[1]), .o_addr(o_addr[1]), .o_data(o_data[1])
  );

  initial CLKEXT = 1'b0;
  always #5 CLKEXT = ~CLKEXT;

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Synchronous-read memories and a saturating MAC, one set per instance.
  always @(posedge CLKEXT) begin
    for (int i = 0; i < 2; i++) begin
      w_rd[i]   <= wmem[w_addr[i]];
      a_rd[i]   <= amem[a_addr[i]];
      b_data[i] <= bmem[b_addr[i]];
      if (reset) acc[i] <= '0;
      else if (EN_MAC[i]) begin
        if (RST_MAC[i]) acc[i] <= {{4{BIAS_OUT[i][7]}}, BIAS_OUT[i], 4'b0000};
        else acc[i] <= sat16(int'(acc[i]) + int'($signed(w_rd[i])) * int'($signed(a_rd[i])));
      end
    end
  end

  assign MAC_result[0] = acc[0];
  assign MAC_result[1] = acc[1];

  // Reference: whole-neuron dot product, then shift/ReLU/clamp.
  function automatic logic [7:0] ref_out(input int j, input bit relu);
    int a;
    int s;
    a = int'($signed(bmem[j])) * 16;
    for (int k = 0; k < N_IN; k++) begin
      a = a + int'($signed(wmem[j*N_IN+k])) * int'($signed(amem[k]));
      if (a > 32767)  a = 32767;
      if (a < -32768) a = -32768;
    end
    s = a >>> 4;
    if (relu && s < 0) s = 0;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic fill(input bit rnd, input int bv, input int av, input int wv);
    for (int n = 0; n < N_OUT; n++) bmem[n] = rnd ? 8'($urandom) : 8'(bv);
    for (int n = 0; n < N_IN; n++)  amem[n] = rnd ? 8'($urandom) : 8'(av);
    for (int n = 0; n < N_IN*N_OUT; n++) wmem[n] = rnd ? 8'($urandom) : 8'(wv);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s busy%0d", tag, i), 32'(busy[i]), 32'd0);
      chk($sformatf("%s done%0d", tag, i), 32'(done[i]), 32'd0);
      chk($sformatf("%s en%0d", tag, i), 32'(EN_MAC[i]), 32'd0);
      chk($sformatf("%s rst%0d", tag, i), 32'(RST_MAC[i]), 32'd0);
      chk($sformatf("%s owr%0d", tag, i), 32'(o_wr[i]), 32'd0);
      chk($sformatf("%s odata%0d", tag, i), 32'(o_data[i]), 32'd0);
      chk($sformatf("%s waddr%0d", tag, i), 32'(w_addr[i]), 32'd0);
      chk($sformatf("%s aaddr%0d", tag, i), 32'(a_addr[i]), 32'd0);
      chk($sformatf("%s baddr%0d", tag, i), 32'(b_addr[i]), 32'd0);
    end
  endtask

  // Start in cycle 0, then check every cycle against position in the layer.
  task automatic run_layer(input string name, input bit noise);
    logic [7:0] exp_o [2][N_OUT];
    int j;
    int p;
    for (int n = 0; n < N_OUT; n++) begin
      exp_o[0][n] = ref_out(n, 1'b1);
      exp_o[1][n] = ref_out(n, 1'b0);
    end
    start = 1'b1;
    chk($sformatf("%s c0 busy", name), 32'(busy[0]), 32'd0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= TOTAL + 2; c++) begin
      j = (c - 1) / PER;
      p = (c - 1) % PER;
      for (int i = 0; i < 2; i++) begin
        if (c <= TOTAL) begin
          chk($sformatf("%s c%0d busy%0d", name, c, i), 32'(busy[i]), 32'd1);
          chk($sformatf("%s c%0d done%0d", name, c, i), 32'(done[i]), 32'd0);
          chk($sformatf("%s c%0d en%0d", name, c, i), 32'(EN_MAC[i]), 32'(p >= 1 && p <= N_IN + 1));
          chk($sformatf("%s c%0d rst%0d", name, c, i), 32'(RST_MAC[i]), 32'(p == 1));
          chk($sformatf("%s c%0d owr%0d", name, c, i), 32'(o_wr[i]), 32'(p == N_IN + 2));
          if (p == 0) begin
            chk($sformatf("%s c%0d baddr%0d", name, c, i), 32'(b_addr[i]), 32'(j));
            chk($sformatf("%s c%0d waddr%0d", name, c, i), 32'(w_addr[i]), 32'(j * N_IN));
            chk($sformatf("%s c%0d aaddr%0d", name, c, i), 32'(a_addr[i]), 32'd0);
          end else if (p <= N_IN) begin
            chk($sformatf("%s c%0d waddr%0d", name, c, i), 32'(w_addr[i]), 32'(j * N_IN + p - 1));
            chk($sformatf("%s c%0d aaddr%0d", name, c, i), 32'(a_addr[i]), 32'(p - 1));
            if (p == 1)
              chk($sformatf("%s c%0d bias%0d", name, c, i), 32'(BIAS_OUT[i]), 32'(bmem[j]));
          end else if (p == N_IN + 2) begin
            chk($sformatf("%s c%0d oaddr%0d", name, c, i), 32'(o_addr[i]), 32'(j));
            chk($sformatf("%s c%0d odata%0d", name, c, i), 32'(o_data[i]), 32'(exp_o[i][j]));
          end
        end else if (c == TOTAL + 1) begin
          chk($sformatf("%s c%0d busy%0d", name, c, i), 32'(busy[i]), 32'd1);
          chk($sformatf("%s c%0d done%0d", name, c, i), 32'(done[i]), 32'd1);
          chk($sformatf("%s c%0d en%0d", name, c, i), 32'(EN_MAC[i]), 32'd0);
          chk($sformatf("%s c%0d owr%0d", name, c, i), 32'(o_wr[i]), 32'd0);
        end
      end
      if (c == TOTAL + 2) check_idle($sformatf("%s c%0d", name, c));
      start = (noise && c <= TOTAL + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill(1'b0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_idle($sformatf("idle c%0d", c));
      tick();
    end

    fill(1'b0, 1, 16, 4);
    run_layer("nominal", 1'b0);

    fill(1'b0, 127, 127, 127);
    run_layer("sat", 1'b1);

    fill(1'b0, 1, 100, 8'hFF);
    run_layer("relu", 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill(1'b1, 0, 0, 0);
      run_layer($sformatf("rand%0d", r), 1'b1);
    end

    // Abort during neuron 1 ACC.
    fill(1'b1, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < PER + 3; c++) tick();
    chk("abort in_acc en", 32'(EN_MAC[0]), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("abort c0");
    for (int c = 1; c < 20; c++) begin
      chk($sformatf("abort c%0d owr", c), 32'(o_wr[0] | o_wr[1]), 32'd0);
      chk($sformatf("abort c%0d done", c), 32'(done[0] | done[1]), 32'd0);
      chk($sformatf("abort c%0d busy", c), 32'(busy[0] | busy[1]), 32'd0);
      tick();
    end
    run_layer("restart", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
